z80_busrq_arbiter: RTL and testbench
====================================

Name: z80_busrq_arbiter

Overview:
- Parametrised multi-master bus-request arbiter for the Z80 top level.
- Collects N DMA/peripheral bus requests and drives the CPU nBUSRQ pin.
- Waits for nBUSACK, then grants the bus to exactly one channel using round-robin priority.
- Optional hold timeout forcibly returns the bus to the CPU. The single-requester control-pin handling does not have this behaviour.

Parameters:
- NCH, 4, number of requesting channels (1..16).
- SYNC_STAGES, 2, flip-flop stages on nBUSACK (0 = used directly, 1..3 allowed).
- MAX_HOLD, 0, maximum grant length in CLK cycles; 0 = unlimited.
- CW, 16, width of the hold counter; MAX_HOLD must be < 2**CW.

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- req  input  NCH  per-channel bus request, level, held until done.
- grant  output  NCH  one-hot grant; at most one bit set.
- nBUSRQ  output  1  to CPU, active low.
- nBUSACK  input  1  from CPU, active low, asynchronous to CLK.
- bus_owned  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- hold_cnt  output  CW  cycles elapsed in the current grant (debug).

Behaviour:
- Reset values: grant=0, nBUSRQ=1, bus_owned=0, timeout=0, hold_cnt=0, state=IDLE, rr_ptr=0. Synchronizer flops reset to 1 (bus not acknowledged).
- ack_s is nBUSACK after SYNC_STAGES flops, inverted (ack_s=1 means the CPU has released the bus).
- FSM states: IDLE, REQ, GRANT, REL.
- IDLE: if any req bit set, register winner = first set bit searching from rr_ptr upward with wrap to 0. Go to REQ and drive nBUSRQ=0 from the next cycle (registered output).
- REQ: hold nBUSRQ=0. When ack_s=1, go to GRANT, set grant[winner], clear hold_cnt.
  - If req[winner] drops while in REQ, go to REL without granting; no grant pulse.
- GRANT: hold_cnt increments each cycle, saturating at all-ones. Exit to REL when either:
  - req[winner]=0: normal release; or
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: forced release; timeout pulses for that cycle.
  - On exit, grant clears in the same edge and nBUSRQ returns to 1.
  - rr_ptr = winner+1, wrapping at NCH.
- REL: nBUSRQ=1, grant=0. Wait for ack_s=0 (CPU has retaken the bus), then return to IDLE.
  - Back-to-back requests always pass through REL, so the CPU gets at least one bus cycle between masters.
- A forcibly released channel still holding req is not re-granted until all other pending channels have been served, because of the rr_ptr advance.
- Request changes on non-winning channels during REQ/GRANT/REL are ignored until IDLE.
- Latency:
  - req to nBUSRQ low: 2 CLK.
  - ack_s to grant: 1 CLK.
  - req drop to grant clear and nBUSRQ high: 1 CLK.
- Glitch on nBUSACK shorter than 1 CLK during GRANT has no effect: grant is held regardless of ack_s in GRANT.
- RESET asserted mid-grant clears everything asynchronously. The CPU sees nBUSRQ=1 immediately.
- NCH=1 degenerates to a simple request/acknowledge wrapper; rr_ptr is constant 0.
- bus_owned = |grant, registered.

Decomposition:
- Shared package z80_bus_pkg:
  - state typedef (IDLE, REQ, GRANT, REL);
  - function rr_pick(req, ptr) returning a one-hot vector and its index.
- One sub-module: z80_sync_n, a parametrised SYNC_STAGES flop chain with reset-to-1, reusable for nWAIT/nINT.

Test Plan:
- NCH=4, req=0100 from reset, nBUSACK model acks 3 CLK after nBUSRQ low -> nBUSRQ low 2 CLK after req; grant=0100 1 CLK after ack_s; release req -> grant=0 and nBUSRQ=1 next CLK.
- req=1111 held permanently, unlimited hold, each channel drops req after 5 cycles then re-raises -> grant order 0001,0010,0100,1000,0001; REL state visited between each.
- MAX_HOLD=8, req[1] held forever -> grant lasts exactly 8 CLK, one timeout pulse, nBUSRQ high; with req[2] also pending, next grant=0100.
- req[3] raised then dropped before ack_s -> no grant bit ever set; FSM goes REL then IDLE once nBUSACK returns high.
- RESET asserted mid-GRANT -> grant=0, nBUSRQ=1 within the same cycle (asynchronous); after RESET release with no req, state stays IDLE.
- SYNC_STAGES=0 vs 2 with identical stimulus -> grant edge shifts by exactly 2 CLK; all other timing unchanged.

Source files
------------

// File: rtl/z80_busrq_arbiter_pkg.sv
// Shared types and helpers for the Z80 bus-request arbiter and its relatives.
package z80_bus_pkg;

  localparam int MAX_CH = 16;  // widest channel vector the round-robin helper handles
  localparam int IDX_W  = 4;   // index width for MAX_CH channels

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    REL
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [MAX_CH-1:0] onehot;
  } rr_pick_t;

  // First set request at or above ptr, wrapping to channel 0; only the low nch bits count.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                       input logic [IDX_W-1:0]  ptr,
                                       input int                nch);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < nch) begin
        j = int'(ptr) + i;
        if (j >= nch) j = j - nch;
        if (!r.valid && req[j[IDX_W-1:0]]) begin
          r.valid                  = 1'b1;
          r.idx                    = j[IDX_W-1:0];
          r.onehot[j[IDX_W-1:0]]   = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/z80_busrq_arbiter_if.sv
// Bus-request handshake bundle: channel requests/grants plus the CPU nBUSRQ/nBUSACK pair.
interface z80_busrq_arbiter_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic           nBUSRQ;
  logic           nBUSACK;
  logic           bus_owned;
  logic           timeout;
  logic [CW-1:0]  hold_cnt;

  // Arbiter side: drives the CPU request and the channel grants.
  modport master (
    input  req, nBUSACK,
    output grant, nBUSRQ, bus_owned, timeout, hold_cnt
  );

  // Requester/CPU side.
  modport slave (
    output req, nBUSACK,
    input  grant, nBUSRQ, bus_owned, timeout, hold_cnt
  );
endinterface

// File: rtl/z80_sync_n.sv
// Flop chain for active-low asynchronous CPU pins (nBUSACK, nWAIT, nINT); resets to inactive.
module z80_sync_n #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_chain
      logic [STAGES-1:0] ff;

      // Shift the pin through STAGES flops; reset to 1 so the pin reads as deasserted.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          ff <= '1;
        end else begin
          ff[0] <= din;
          for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
      end

      assign dout = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/z80_busrq_arbiter.sv
// Round-robin arbiter that requests the Z80 bus via nBUSRQ and hands it to one channel at a time.
module z80_busrq_arbiter
  import z80_bus_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_HOLD    = 0,
  parameter int CW          = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  z80_busrq_arbiter_if.master bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_e     state, stateNext;
  logic [PW-1:0]  winner, winnerNext;
  logic [PW-1:0]  rrPtr, rrPtrNext;
  logic [NCH-1:0] grantNext;
  logic           nBusrqNext;
  logic           timeoutNext;
  logic [CW-1:0]  holdCntNext;
  logic           ackSyncN;
  logic           ackS;
  logic           holdExpired;
  rr_pick_t       pick;
  logic           unusedPick;

  z80_sync_n #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .din   (bus.nBUSACK),
    .dout  (ackSyncN)
  );

  assign ackS        = ~ackSyncN;
  assign pick        = rr_pick(MAX_CH'(bus.req), IDX_W'(rrPtr), NCH);
  assign unusedPick  = ^pick.onehot;
  assign holdExpired = (MAX_HOLD != 0) && (bus.hold_cnt == HOLD_LAST);

  // Next-state, grant and registered-output decode for the four-state handshake.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext   = state;
    winnerNext  = winner;
    rrPtrNext   = rrPtr;
    grantNext   = '0;
    nBusrqNext  = 1'b1;
    timeoutNext = 1'b0;
    holdCntNext = '0;
    unique case (state)
      IDLE: begin
        if (pick.valid) begin
          stateNext  = REQ;
          winnerNext = PW'(pick.idx);
        end
      end
      REQ: begin
        if (!bus.req[winner]) begin
          stateNext = REL;  // requester gave up before the CPU let go: no grant
        end else begin
          nBusrqNext = 1'b0;
          if (ackS) begin
            stateNext = GRANT;
            grantNext = NCH'(1) << winner;
          end
        end
      end
      GRANT: begin
        if (!bus.req[winner] || holdExpired) begin
          stateNext   = REL;
          rrPtrNext   = (int'(winner) == NCH - 1) ? '0 : winner + 1'b1;
          timeoutNext = bus.req[winner];
        end else begin
          nBusrqNext  = 1'b0;
          grantNext   = bus.grant;
          holdCntNext = (bus.hold_cnt == '1) ? bus.hold_cnt : bus.hold_cnt + 1'b1;
        end
      end
      REL: begin
        // Wait for the CPU to retake the bus so it always gets a cycle between masters.
        if (!ackS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, round-robin pointer and all outputs are registered.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      winner        <= '0;
      rrPtr         <= '0;
      bus.grant     <= '0;
      bus.nBUSRQ    <= 1'b1;
      bus.bus_owned <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.hold_cnt  <= '0;
    end else begin
      state         <= stateNext;
      winner        <= winnerNext;
      rrPtr         <= rrPtrNext;
      bus.grant     <= grantNext;
      bus.nBUSRQ    <= nBusrqNext;
      bus.bus_owned <= |grantNext;
      bus.timeout   <= timeoutNext;
      bus.hold_cnt  <= holdCntNext;
    end
  end

endmodule

// File: tb/tb_z80_busrq_arbiter.sv
// Directed bench for z80_busrq_arbiter: three instances (sync 2 / hold-limited / sync 0).
module tb_z80_busrq_arbiter;
  import z80_bus_pkg::*;

  localparam int ACK_DELAY = 3;  // CPU model samples nBUSRQ low this many times before acking

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z80_busrq_arbiter_if #(.NCH(4), .CW(16)) ifA ();
  z80_busrq_arbiter_if #(.NCH(4), .CW(16)) ifB ();
  z80_busrq_arbiter_if #(.NCH(4), .CW(16)) ifC ();

  z80_busrq_arbiter #(.NCH(4), .SYNC_STAGES(2), .MAX_HOLD(0), .CW(16)) dutA (
    .CLK(clk), .RESET(rst), .bus(ifA.master));
  z80_busrq_arbiter #(.NCH(4), .SYNC_STAGES(2), .MAX_HOLD(8), .CW(16)) dutB (
    .CLK(clk), .RESET(rst), .bus(ifB.master));
  z80_busrq_arbiter #(.NCH(4), .SYNC_STAGES(0), .MAX_HOLD(0), .CW(16)) dutC (
    .CLK(clk), .RESET(rst), .bus(ifC.master));

  int         passCnt  = 0;
  int         totalCnt = 0;
  logic [3:0] expQ[$];

  // CPU model: acks after ACK_DELAY negedges of nBUSRQ low, releases as soon as nBUSRQ is high.
  initial begin : cpu_model
    int cntA, cntB, cntC;
    cntA = 0; cntB = 0; cntC = 0;
    ifA.nBUSACK = 1'b1; ifB.nBUSACK = 1'b1; ifC.nBUSACK = 1'b1;
    forever begin
      @(negedge clk);
      cntA = (rst || ifA.nBUSRQ) ? 0 : ((cntA < ACK_DELAY) ? cntA + 1 : cntA);
      cntB = (rst || ifB.nBUSRQ) ? 0 : ((cntB < ACK_DELAY) ? cntB + 1 : cntB);
      cntC = (rst || ifC.nBUSRQ) ? 0 : ((cntC < ACK_DELAY) ? cntC + 1 : cntC);
      ifA.nBUSACK = !(cntA >= ACK_DELAY);
      ifB.nBUSACK = !(cntB >= ACK_DELAY);
      ifC.nBUSACK = !(cntC >= ACK_DELAY);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] grant_of(input int d);
    case (d)
      0:       return ifA.grant;
      1:       return ifB.grant;
      default: return ifC.grant;
    endcase
  endfunction

  function automatic logic [1:0] state_of(input int d);
    case (d)
      0:       return dutA.state;
      1:       return dutB.state;
      default: return dutC.state;
    endcase
  endfunction

  // Wait (bounded) for a grant on instance d, then pop and compare the scoreboard entry.
  task automatic wait_grant(input string tag, input int d, input int budget, output int waited);
    logic [3:0] exp;
    waited = 0;
    while (grant_of(d) == 4'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    exp = (expQ.size() != 0) ? expQ.pop_front() : 4'bxxxx;
    check(tag, 32'(grant_of(d)), 32'(exp));
  endtask

  task automatic wait_idle(input string tag, input int d, input int budget);
    int n;
    n = 0;
    while (state_of(d) != 2'(IDLE) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state_of(d)), 32'(IDLE));
  endtask

  initial begin : stimulus
    int         w, wc, wa, len;
    logic [3:0] exp, gOr;
    ifA.req = '0; ifB.req = '0; ifC.req = '0;

    // Reset values.
    @(negedge clk);
    check("rst_grant", 32'(ifA.grant), 0);
    check("rst_nbusrq", 32'(ifA.nBUSRQ), 1);
    check("rst_bus_owned", 32'(ifA.bus_owned), 0);
    check("rst_timeout", 32'(ifA.timeout), 0);
    check("rst_hold_cnt", 32'(ifA.hold_cnt), 0);
    check("rst_state", 32'(state_of(0)), 32'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: nBUSRQ latency, grant latency through 2-flop sync, 1-CLK release.
    ifA.req = 4'b0100;
    @(negedge clk); check("t1_nbusrq_1clk", 32'(ifA.nBUSRQ), 1);
    @(negedge clk); check("t1_nbusrq_2clk", 32'(ifA.nBUSRQ), 0);
    expQ.push_back(4'b0100);
    wait_grant("t1_grant", 0, 20, w);
    check("t1_grant_latency", w, 5);
    check("t1_bus_owned", 32'(ifA.bus_owned), 1);
    ifA.req = '0;
    @(negedge clk);
    check("t1_release_grant", 32'(ifA.grant), 0);
    check("t1_release_nbusrq", 32'(ifA.nBUSRQ), 1);
    check("t1_release_owned", 32'(ifA.bus_owned), 0);
    wait_idle("t1_idle", 0, 20);

    // Request withdrawn before the CPU acks: no grant, REL then IDLE.
    ifA.req = 4'b1000;
    repeat (2) @(negedge clk);
    check("t4_nbusrq_low", 32'(ifA.nBUSRQ), 0);
    ifA.req = '0;
    @(negedge clk);
    check("t4_nbusrq_high", 32'(ifA.nBUSRQ), 1);
    check("t4_state_rel", 32'(state_of(0)), 32'(REL));
    @(negedge clk);
    check("t4_state_idle", 32'(state_of(0)), 32'(IDLE));
    gOr = '0;
    repeat (10) begin @(negedge clk); gOr |= ifA.grant; end
    check("t4_no_grant", 32'(gOr), 0);

    // Reset in the middle of a grant clears outputs asynchronously.
    ifA.req = 4'b0010;
    expQ.push_back(4'b0010);
    wait_grant("t5_grant", 0, 30, w);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_grant", 32'(ifA.grant), 0);
    check("t5_async_nbusrq", 32'(ifA.nBUSRQ), 1);
    check("t5_async_hold", 32'(ifA.hold_cnt), 0);
    ifA.req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idle_after", 32'(state_of(0)), 32'(IDLE));
    check("t5_nbusrq_after", 32'(ifA.nBUSRQ), 1);

    // Round robin with all four channels requesting; each releases after 5 cycles.
    ifA.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      expQ.push_back(exp);
      wait_grant($sformatf("t2_grant%0d", k), 0, 40, w);
      check($sformatf("t2_hold0_%0d", k), 32'(ifA.hold_cnt), 0);
      repeat (4) @(negedge clk);
      check($sformatf("t2_hold4_%0d", k), 32'(ifA.hold_cnt), 4);
      ifA.req = 4'b1111 & ~exp;
      @(negedge clk);
      check($sformatf("t2_drop%0d", k), 32'(ifA.grant), 0);
      check($sformatf("t2_rel%0d", k), 32'(state_of(0)), 32'(REL));
      ifA.req = 4'b1111;
    end
    ifA.req = '0;
    wait_idle("t2_idle", 0, 40);

    // Hold limit of 8 with channel 1 never letting go; channel 2 joins meanwhile.
    ifB.req = 4'b0010;
    expQ.push_back(4'b0010);
    wait_grant("t6_grant", 1, 40, w);
    ifB.req = 4'b0110;
    len = 0;
    while (ifB.grant != 4'b0 && len < 40) begin
      len++;
      @(negedge clk);
    end
    check("t6_grant_len", len, 8);
    check("t6_timeout_pulse", 32'(ifB.timeout), 1);
    check("t6_nbusrq_high", 32'(ifB.nBUSRQ), 1);
    @(negedge clk);
    check("t6_timeout_end", 32'(ifB.timeout), 0);
    expQ.push_back(4'b0100);
    wait_grant("t6_next_ch2", 1, 40, w);
    ifB.req = 4'b0010;
    @(negedge clk);
    check("t6_ch2_released", 32'(ifB.grant), 0);
    check("t6_no_timeout", 32'(ifB.timeout), 0);
    expQ.push_back(4'b0010);
    wait_grant("t6_back_to_ch1", 1, 40, w);
    ifB.req = '0;
    wait_idle("t6_idle", 1, 40);

    // Same stimulus on 0-stage and 2-stage instances: only the grant edge moves, by 2 CLK.
    ifA.req = 4'b0001;
    ifC.req = 4'b0001;
    repeat (2) @(negedge clk);
    check("t7_a_nbusrq", 32'(ifA.nBUSRQ), 0);
    check("t7_c_nbusrq", 32'(ifC.nBUSRQ), 0);
    expQ.push_back(4'b0001);
    wait_grant("t7_grant_c", 2, 20, wc);
    check("t7_c_latency", wc, 3);
    expQ.push_back(4'b0001);
    wait_grant("t7_grant_a", 0, 20, wa);
    check("t7_shift", wa, 2);
    ifA.req = '0;
    ifC.req = '0;
    @(negedge clk);
    check("t7_a_release", 32'({ifA.grant, ifA.nBUSRQ}), 32'b0_0000_1);
    check("t7_c_release", 32'({ifC.grant, ifC.nBUSRQ}), 32'b0_0000_1);
    wait_idle("t7_a_idle", 0, 20);
    wait_idle("t7_c_idle", 2, 20);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
